// File: rtl/cond_pkg.sv
// Shared definitions for the condition unit: condition-code encodings and
// flag bit positions inside the {N,Z,C,V} flag word.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'd0,
    NE = 4'd1,
    HS = 4'd2,
    LO = 4'd3,
    MI = 4'd4,
    PL = 4'd5,
    VS = 4'd6,
    VC = 4'd7,
    HI = 4'd8,
    LS = 4'd9,
    GE = 4'd10,
    LT = 4'd11,
    GT = 4'd12,
    LE = 4'd13,
    AL = 4'd14,
    NV = 4'd15
  } cond_e;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;  // borrow: set when In1 < In2 unsigned
  localparam int V_BIT = 0;

endpackage

// File: rtl/cond_unit_if.sv
// Request/response channel between a requester and the condition unit.
// Handshake: a beat transfers on a cycle where valid=1 and ready=1; the sender
// holds valid and its payload stable until that cycle, and ready may depend
// combinationally on the receiver's state but never on valid.
interface cond_unit_if;
  import cond_pkg::*;

  logic       req_valid;
  logic [3:0] req_cond;
  logic       req_ready;
  logic       resp_valid;
  logic       resp_taken;
  logic       resp_ready;

  modport master (
    output req_valid,
    output req_cond,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_taken
  );

  modport slave (
    input  req_valid,
    input  req_cond,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_taken
  );

endinterface

// File: rtl/cond_eval.sv
// Pure combinational condition evaluator: decides whether a condition code
// holds for a given {N,Z,C,V} flag word (C is a borrow flag).
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       taken
);

  logic n, z, c, v;

  assign n = flags[N_BIT];
  assign z = flags[Z_BIT];
  assign c = flags[C_BIT];
  assign v = flags[V_BIT];

  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      EQ: taken = z;
      NE: taken = !z;
      HS: taken = !c;
      LO: taken = c;
      MI: taken = n;
      PL: taken = !n;
      VS: taken = v;
      VC: taken = !v;
      HI: taken = !c && !z;
      LS: taken = c || z;
      GE: taken = (n == v);
      LT: taken = (n != v);
      GT: taken = !z && (n == v);
      LE: taken = z || (n != v);
      AL: taken = 1'b1;
      NV: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Condition unit: owns the architectural flag register, evaluates condition
// requests with a one-cycle registered response, and counts taken results.
module cond_unit
  import cond_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flag_s,
  input  logic [3:0]       flags_in,
  cond_unit_if.slave       bus,
  output logic [3:0]       flags_q,
  output logic [CNT_W-1:0] taken_cnt
);

  logic [3:0] eff_flags;
  logic       eval_taken;
  logic       accept;
  logic       resp_valid_q;
  logic       resp_taken_q;

  // A flag write in the same cycle as a request is visible to that request.
  assign eff_flags = flag_s ? flags_in : flags_q;

  cond_eval u_eval (
    .flags (eff_flags),
    .cond  (bus.req_cond),
    .taken (eval_taken)
  );

  assign bus.req_ready  = !resp_valid_q || bus.resp_ready;
  assign accept         = bus.req_valid && bus.req_ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_taken = resp_taken_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q      <= 4'b0000;
      resp_valid_q <= 1'b0;
      resp_taken_q <= 1'b0;
      taken_cnt    <= '0;
    end else begin
      if (flag_s) begin
        flags_q <= flags_in;
      end
      // resp_taken only moves on acceptance, so a stalled response is frozen.
      if (accept) begin
        resp_valid_q <= 1'b1;
        resp_taken_q <= eval_taken;
        if (eval_taken && (taken_cnt != {CNT_W{1'b1}})) begin
          taken_cnt <= taken_cnt + CNT_W'(1);
        end
      end else if (bus.resp_ready) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the taken-branch statistics counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port flag_s  input  1  flag-write strobe from the flag generator; 1 = flags_in valid this cycle.
REQ-005 SHALL have port flags_in  input  4  the flags as {N,Z,C,V}; bit 3 = N, bit 2 = Z, bit 1 = C (borrow: 1 when In1 < In2 unsigned), bit 0 = V.
REQ-006 SHALL have port req_valid  input  1  a condition-evaluation request is present.
REQ-007 SHALL have port req_cond  input  4  the condition code to evaluate.
REQ-008 SHALL have port req_ready  output  1  the block accepts the request this cycle.
REQ-009 SHALL have port resp_valid  output  1  resp_taken is valid.
REQ-010 SHALL have port resp_taken  output  1  the evaluated condition result.
REQ-011 SHALL have port resp_ready  input  1  the consumer accepts the response.
REQ-012 SHALL have port flags_q  output  4  the architectural flag register.
REQ-013 SHALL have port taken_cnt  output  CNT_W  saturating count of accepted requests evaluated true.

Function
REQ-014 SHALL load flags_q <= flags_in on a clock edge when flag_s=1, and SHALL hold flags_q when flag_s=0; flags_in is ignored when flag_s=0.
REQ-015 SHALL accept a request on a cycle with req_valid=1 and req_ready=1.
REQ-016 SHALL drive req_ready = !resp_valid || resp_ready, combinationally.
REQ-017 SHALL evaluate an accepted request against the effective flags: flags_in when flag_s=1 in the same cycle (bypass), else flags_q.
REQ-018 SHALL map the condition codes as follows (C is borrow):
- 0 EQ: Z
- 1 NE: !Z
- 2 HS: !C
- 3 LO: C
- 4 MI: N
- 5 PL: !N
- 6 VS: V
- 7 VC: !V
- 8 HI: !C&!Z
- 9 LS: C|Z
- 10 GE: N==V
- 11 LT: N!=V
- 12 GT: !Z&(N==V)
- 13 LE: Z|(N!=V)
- 14 AL: 1
- 15 NV: 0
REQ-019 SHALL register the result so that resp_valid=1 and resp_taken are presented on the cycle after acceptance (latency 1).
REQ-020 SHALL hold resp_valid and resp_taken stable while resp_valid=1 and resp_ready=0.
REQ-021 SHALL clear resp_valid on a resp_ready=1 cycle when no new request is accepted; SHALL replace the response on a cycle with both acceptance and resp_ready=1, sustaining one response per cycle.
REQ-022 SHALL NOT let a flag write during a stalled response alter the held resp_taken.
REQ-023 SHALL increment taken_cnt by 1 per accepted request whose result is 1, saturating at 2^CNT_W-1.

Reset
REQ-024 SHALL, while rst=1 at a clock edge, set flags_q=4'b0000, resp_valid=0, resp_taken=0, taken_cnt=0; rst has priority over flag_s and over request acceptance.
REQ-025 SHALL drop any held or in-flight response when rst is asserted mid-operation; req_ready SHALL equal 1 in the first cycle after reset.

Structure
REQ-026 SHALL take the 4-bit condition-code constants (EQ..NV) and the flag bit indices N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0 from a shared package cond_pkg.
REQ-027 SHALL implement the REQ-018 mapping in one combinational sub-module cond_eval (inputs flags[3:0], cond[3:0]; output taken).

Verification
REQ-028 SHALL have a bench scenario: flag_s=1, flags_in=4'b0100; next cycle request cond=EQ -> resp_valid=1 with resp_taken=1 one cycle later; cond=NE -> resp_taken=0.
REQ-029 SHALL have a bench scenario: flags_q=0000; flag_s=1, flags_in=4'b0010 in the same cycle as a request with cond=LO -> resp_taken=1 (bypass); flags_q=0010 afterwards.
REQ-030 SHALL have a bench scenario: a response held with resp_ready=0 for 3 cycles while flag_s writes new flags -> req_ready=0 and resp_taken unchanged; resp_ready=1 -> handed off, req_ready=1.
REQ-031 SHALL have a bench scenario: back-to-back requests on every cycle with resp_ready=1 -> one response per cycle, in order.
REQ-032 SHALL have a bench scenario: sweep all 16 codes over all 16 flag values -> results match REQ-018, with AL always 1 and NV always 0.
REQ-033 SHALL have a bench scenario: rst asserted with a response pending and taken_cnt=5 -> resp_valid=0, taken_cnt=0, flags_q=0000 next cycle; with CNT_W=2, 5 taken requests -> taken_cnt=3.
